// File: rtl/riscv_pkg.sv
// Shared definitions for the execute-stage ALU.
//   - ALU operation codes as produced by the ALU control unit (4 bits).
//     Codes above ALU_SLT are not defined and execute as ADD.
//   - Default datapath width.
//   - Execute-stage FSM state encoding and the shift-kind encoding that the
//     iterative shifter latches.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter_iter.sv
// Iterative one-bit-per-cycle shifter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start_i     load operand_i / shamt_i / kind_i (only when idle, shamt_i != 0)
//   kind_i      SLL / SRL / SRA
//   shamt_i     shift amount, 1..31
//   operand_i   value to shift
//   done_o      high in the cycle whose closing edge completes the final step
//   result_o    accumulator after one more step; equals the final result when
//               done_o is high, so the caller registers it on that same edge
module alu_shifter_iter
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  shift_kind_e     kind_i,
  input  logic [4:0]      shamt_i,
  input  logic [XLEN-1:0] operand_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  logic [XLEN-1:0] acc_q, acc_d, acc_step;
  logic [4:0]      cnt_q, cnt_d;
  shift_kind_e     kind_q, kind_d;

  always_comb begin
    acc_step = acc_q;
    case (kind_q)
      SH_SLL:  acc_step = {acc_q[XLEN-2:0], 1'b0};
      SH_SRL:  acc_step = {1'b0, acc_q[XLEN-1:1]};
      SH_SRA:  acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    if (start_i) begin
      acc_d  = operand_i;
      cnt_d  = shamt_i;
      kind_d = kind_i;
    end else if (cnt_q != 5'd0) begin
      acc_d  = acc_step;
      cnt_d  = cnt_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      cnt_q  <= 5'd0;
      kind_q <= SH_SLL;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
    end
  end

  assign done_o   = (cnt_q == 5'd1);
  assign result_o = acc_step;

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU for the 32-bit RISC-V core.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid may be raised or dropped at any time, ready never depends on
// valid, and an offered result (out_valid) stays stable until taken.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operation offer / stage can accept
//   alu_ctrl, op_a, op_b  4-bit op code and operands
//   out_valid / out_ready result offer / consumer accepts
//   result, zero          registered result and (result == 0)
//   busy                  iterative shift in progress
// Single-cycle ops finish on the accept edge. Shifts with a nonzero amount
// take one cycle per bit unless FAST_SHIFT=1, which uses a barrel shift.
module alu_exec_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter bit FAST_SHIFT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  alu_state_e      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;
  logic            accept;
  logic            go_iter;
  logic            shift_done;
  logic [XLEN-1:0] shift_res;

  assign shamt = op_b[4:0];

  // Single-cycle datapath, including the barrel shift. In iterative mode the
  // barrel shift is only selected for shamt 0, where it reduces to op_a.
  always_comb begin
    alu_res = op_a + op_b;
    case (alu_ctrl)
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_SLL: alu_res = op_a << shamt;
      ALU_SRL: alu_res = op_a >> shamt;
      ALU_SRA: alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = op_a + op_b;
    endcase
  end

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign go_iter  = accept && !FAST_SHIFT && is_shift_op(alu_ctrl) && (shamt != 5'd0);

  generate
    if (FAST_SHIFT == 1'b0) begin : g_iter
      shift_kind_e kind;
      always_comb begin
        kind = SH_SLL;
        if (alu_ctrl == ALU_SRL)      kind = SH_SRL;
        else if (alu_ctrl == ALU_SRA) kind = SH_SRA;
      end

      alu_shifter_iter #(.XLEN(XLEN)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (go_iter),
        .kind_i    (kind),
        .shamt_i   (shamt),
        .operand_i (op_a),
        .done_o    (shift_done),
        .result_o  (shift_res)
      );
    end else begin : g_fast
      assign shift_done = 1'b0;
      assign shift_res  = '0;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (go_iter) begin
            state_d = ST_SHIFT;
          end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d  = ST_DONE;
          result_d = shift_res;
          zero_d   = (shift_res == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        busy;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  alu_exec_stage #(.XLEN(32), .FAST_SHIFT(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [63:0] ext;
    sh  = b % 32;
    ext = {{32{a[31]}}, a};
    case (c)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return ext[31:0] >> 0 == 0 ? 32'(ext >> sh) : 32'(ext >> sh);
      4'd8:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] c, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    if ((c == 4'd5 || c == 4'd6 || c == 4'd7) && sh != 0) return int'(sh) + 1;
    return 1;
  endfunction

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: inputs and registered outputs are stable and
  // hold the values the next rising edge will act on.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_spurious_out", {31'b0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", result, e);
          check("sb_zero", {31'b0, zero}, {31'b0, (e == 32'd0)});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_alu(alu_ctrl, op_a, op_b));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 with the stage idle and out_ready=1.
  task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    int lat;
    int lat_exp;
    logic [31:0] e;
    e       = ref_alu(c, a, b);
    lat_exp = ref_latency(c, b);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = $urandom; op_b = $urandom; alu_ctrl = 4'($urandom_range(0, 15));
    lat = 1;
    while (!out_valid && lat < 40) begin
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_result"}, result, e);
    check({tag, "_zero"}, {31'b0, zero}, {31'b0, (e == 32'd0)});
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a4[4];
    logic [31:0] b4[4];
    logic stale;
    int waited;
    n_vec = 0; n_err = 0;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = 4'd0; op_a = '0; op_b = '0;
    #3 rst_n = 1'b0;
    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // directed single-cycle ops
    do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001);
    do_op("sub_zero", 4'd1, 32'd5, 32'd5);
    do_op("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'd1);
    do_op("code_b", 4'b1011, 32'd2, 32'd3);
    do_op("xor", 4'd4, 32'hA5A5_0F0F, 32'hFFFF_0000);

    // shifts
    do_op("sra4", 4'd7, 32'h8000_0000, 32'h0000_0024);
    do_op("sll0", 4'd5, 32'h1234_5678, 32'h0000_0020);
    do_op("sra31", 4'd7, 32'h8000_0001, 32'd31);
    do_op("srl3", 4'd6, 32'hF000_000F, 32'hFFFF_FFE3);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 4'd0; op_a = 32'h10; op_b = 32'h2;
    @(posedge clk); #1;
    alu_ctrl = 4'd0; op_a = 32'd1; op_b = 32'd1;
    repeat (3) begin
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result", result, 32'h12);
      check("bp_zero", {31'b0, zero}, 32'd0);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_valid", {31'b0, out_valid}, 32'd1);
    check("bp_next_result", result, 32'd2);
    @(posedge clk); #1;

    // back-to-back
    for (int i = 0; i < 4; i++) begin
      a4[i] = $urandom; b4[i] = $urandom;
      in_valid = 1'b1; alu_ctrl = 4'd0; op_a = a4[i]; op_b = b4[i];
      @(posedge clk); #1;
      check("b2b_valid", {31'b0, out_valid}, 32'd1);
      check("b2b_sum", result, a4[i] + b4[i]);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_drained", {31'b0, out_valid}, 32'd0);

    // reset mid-shift
    in_valid = 1'b1; alu_ctrl = 4'd6; op_a = 32'hF0F0_1234; op_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    stale = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("post_rst_no_stale", {31'b0, stale}, 32'd0);

    // randomized traffic, checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_ctrl  = 4'($urandom_range(0, 15));
      op_a      = $urandom;
      op_b      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 7) == 0) op_a = op_b;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    waited = 0;
    while ((exp_q.size() != 0 || busy || out_valid) && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_queue", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
